alu_seq: RTL and testbench

Parametrised, handshaked sequential ALU: the next-generation execution unit of the CPU datapath. It keeps the arithmetic/logic split selected by `mode` plus a 5-bit opcode, and the operand-compare flags. It adds operand width as a parameter, registered outputs, and a valid/ready handshake on both sides. It also adds multi-cycle multiply and divide, carry and error flags. It sits between the register-file read stage and writeback; the control unit issues one operation at a time and waits for `out_valid`.

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops give out_valid one cycle after accept; MUL/DIV give it W+1 cycles after accept.
// Accepts only in IDLE (in_ready). Results are held in DONE until out_ready, then the unit returns to IDLE.
module alu_seq #(
  parameter int W   = 19,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [4:0]   opcode,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         za,
  output logic         zb,
  output logic         eq,
  output logic         gt,
  output logic         lt,
  output logic         cout,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(W - 1);
  localparam logic [W:0]     ONE  = 1;

  state_t         state;
  logic [SHW-1:0] cnt;
  logic [W-1:0]   hi_q, lo_q, opd_q;
  logic           mul_q;

  logic           multi;
  logic [W-1:0]   s_res, s_hi;
  logic           s_cout, s_err;
  logic [W:0]     mul_add, div_sh, div_dif;
  logic [W-1:0]   step_hi, step_lo;

  assign in_ready = (state == IDLE) && !rst;
  assign multi    = !mode && (opcode == 5'd4 || (opcode == 5'd5 && b != '0));

  always_comb begin
    s_res  = '0;
    s_hi   = '0;
    s_cout = 1'b0;
    s_err  = 1'b0;
    case ({mode, opcode})
      6'h00: {s_cout, s_res} = {1'b0, a} + {1'b0, b};
      6'h01: {s_cout, s_res} = {1'b0, a} - {1'b0, b};
      6'h02: {s_cout, s_res} = {1'b0, a} + ONE;
      6'h03: {s_cout, s_res} = {1'b0, a} - ONE;
      // Only reached with b == 0; nonzero divisors take the iterative path.
      6'h05: begin
        s_res = '1;
        s_hi  = a;
        s_err = 1'b1;
      end
      6'h20: s_res = a & b;
      6'h21: s_res = a | b;
      6'h22: s_res = a ^ b;
      6'h23: s_res = ~a;
      6'h24: s_res = ~(a & b);
      6'h25: s_res = ~(a | b);
      6'h26: s_res = a << b[SHW-1:0];
      6'h27: s_res = a >> b[SHW-1:0];
      default: s_err = 1'b1;
    endcase
  end

  // Multiply: hi accumulates the multiplicand, {hi,lo} shifts right each step.
  // Divide: {rem,quo} shifts left, subtract divisor when it fits (restoring).
  always_comb begin
    mul_add = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh  = {hi_q, lo_q[W-1]};
    div_dif = div_sh - {1'b0, opd_q};
    if (mul_q) begin
      step_hi = mul_add[W:1];
      step_lo = {mul_add[0], lo_q[W-1:1]};
    end else if (div_sh >= {1'b0, opd_q}) begin
      step_hi = div_dif[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b1};
    end else begin
      step_hi = div_sh[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      mul_q     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      za        <= 1'b0;
      zb        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          za <= (a == '0);
          zb <= (b == '0);
          eq <= (a == b);
          gt <= (a > b);
          lt <= (a < b);
          if (multi) begin
            mul_q <= !opcode[0];
            opd_q <= opcode[0] ? b : a;
            lo_q  <= opcode[0] ? a : b;
            hi_q  <= '0;
            cnt   <= '0;
            state <= BUSY;
          end else begin
            result    <= s_res;
            result_hi <= s_hi;
            cout      <= s_cout;
            err       <= s_err;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        BUSY: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= step_lo;
            result_hi <= step_hi;
            cout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq, checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 19;
  localparam longint unsigned M = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0]   opcode = '0;
  logic         mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result, result_hi;
  logic         za, zb, eq, gt, lt, cout, err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the operation table, using wide integer arithmetic.
  task automatic model(input bit m, input int op, input longint unsigned x, input longint unsigned y,
                       output longint unsigned r, output longint unsigned h,
                       output bit c, output bit e, output int lat);
    longint unsigned s;
    r = 0; h = 0; c = 0; e = 0; lat = 1;
    s = y % 32;
    if (!m) begin
      case (op)
        0: begin r = (x + y) % M; c = (x + y) >= M; end
        1: begin r = (x + M - y) % M; c = x < y; end
        2: begin r = (x + 1) % M; c = (x + 1) >= M; end
        3: begin r = (x + M - 1) % M; c = (x == 0); end
        4: begin r = (x * y) % M; h = (x * y) / M; lat = W + 1; end
        5: if (y == 0) begin r = M - 1; h = x; e = 1; end
           else begin r = x / y; h = x % y; lat = W + 1; end
        default: e = 1;
      endcase
    end else begin
      case (op)
        0: r = x & y;
        1: r = x | y;
        2: r = x ^ y;
        3: r = (M - 1) - x;
        4: r = (M - 1) - (x & y);
        5: r = (M - 1) - (x | y);
        6: r = (s >= W) ? 0 : (x << s) % M;
        7: r = (s >= W) ? 0 : x >> s;
        default: e = 1;
      endcase
    end
  endtask

  task automatic do_op(input bit m, input int op, input longint unsigned x, input longint unsigned y,
                       input int hold);
    longint unsigned er, eh;
    bit ec, ee;
    int elat, n, lat;
    logic [W-1:0] r0, h0;
    model(m, op, x, y, er, eh, ec, ee, elat);
    @(negedge clk);
    mode = m; opcode = 5'(op); a = W'(x); b = W'(y); in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); opcode = 5'($urandom); mode = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk($sformatf("lat m%0d op%0d", m, op), lat, elat);
    chk($sformatf("res m%0d op%0d a=%0h b=%0h", m, op, x, y), result, er);
    chk($sformatf("hi m%0d op%0d", m, op), result_hi, eh);
    chk("cout", cout, ec);
    chk("err", err, ee);
    chk("flags", {za, zb, eq, gt, lt}, {x == 0, y == 0, x == y, x > y, x < y});
    chk("in_ready_done", in_ready, 1'b0);
    r0 = result; h0 = result_hi;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      chk("hold_res", {result, result_hi}, {W'(er), W'(eh)});
      chk("hold_vld", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release", {out_valid, in_ready}, 2'b01);
    chk("stable_after", {result, result_hi}, {r0, h0});
  endtask

  always @(negedge clk)
    if (!rst && in_ready && out_valid) chk("ready_valid_overlap", 1'b1, 1'b0);

  initial begin
    int seen;
    longint unsigned x, y;
    int op;
    repeat (3) @(negedge clk);
    chk("rst_outs", {out_valid, result, result_hi, za, zb, eq, gt, lt, cout, err}, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    do_op(0, 0, 64'h7FFFF, 1, 0);
    do_op(0, 1, 5, 9, 0);
    do_op(0, 1, 9, 9, 0);
    do_op(0, 4, 1000, 1000, 0);
    do_op(0, 5, 100, 7, 5);
    do_op(0, 5, 100, 0, 0);
    do_op(0, 3, 0, 3, 0);
    do_op(0, 4, M - 1, M - 1, 0);
    do_op(0, 5, M - 1, 1, 0);
    do_op(1, 7, 64'h40000, 18, 0);
    do_op(1, 6, 5, 19, 0);

    // Abort a multiply with reset partway through.
    @(negedge clk);
    mode = 1'b0; opcode = 5'd4; a = W'(1000); b = W'(1000); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", {out_valid, result, result_hi, za, zb, eq, gt, lt, cout, err}, '0);
    chk("abort_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    do_op(1, 6, 3, 2, 0);
    do_op(0, 15, 7, 7, 0);

    for (int i = 0; i < 150; i++) begin
      x = longint'($urandom) % M;
      y = longint'($urandom) % M;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: y = $urandom_range(1, 9);
        2: x = M - 1;
        3: y = x;
        default: ;
      endcase
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      do_op(1'($urandom), op, x, y, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
